// File: rtl/btb_update_sched_if.sv
// rtl/btb_update_sched_if.sv - requester, flush and BTB-update signal bundle for btb_update_sched
interface btb_update_sched_if #(
    parameter int DEPTH = 4
);
    logic                         req0_valid_i;
    logic                         req0_ready_o;
    logic [63:0]                  req0_pc_i;
    logic [63:0]                  req0_target_i;
    logic                         req0_taken_i;
    logic                         req1_valid_i;
    logic                         req1_ready_o;
    logic [63:0]                  req1_pc_i;
    logic [63:0]                  req1_target_i;
    logic                         req1_taken_i;
    logic                         flush_i;
    logic                         flush_busy_o;
    logic                         btb_upd_valid_o;
    logic [63:0]                  btb_upd_pc_o;
    logic [63:0]                  btb_upd_target_o;
    logic                         btb_upd_taken_o;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count_o;

    modport master (
        output req0_valid_i, req0_pc_i, req0_target_i, req0_taken_i,
        output req1_valid_i, req1_pc_i, req1_target_i, req1_taken_i,
        output flush_i,
        input  req0_ready_o, req1_ready_o, flush_busy_o,
        input  btb_upd_valid_o, btb_upd_pc_o, btb_upd_target_o, btb_upd_taken_o,
        input  fifo_count_o
    );

    modport slave (
        input  req0_valid_i, req0_pc_i, req0_target_i, req0_taken_i,
        input  req1_valid_i, req1_pc_i, req1_target_i, req1_taken_i,
        input  flush_i,
        output req0_ready_o, req1_ready_o, flush_busy_o,
        output btb_upd_valid_o, btb_upd_pc_o, btb_upd_target_o, btb_upd_taken_o,
        output fifo_count_o
    );
endinterface

// File: rtl/btb_update_sched.sv
// rtl/btb_update_sched.sv - two-requester BTB update FIFO with invalidate-all walker
// Optional same-PC coalescing into the youngest queued entry: BTB_UPD_COALESCE_EN.
module btb_update_sched #(
    parameter int DEPTH   = 4,
    parameter int SETS    = 4096,
    parameter int IDX_LSB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    btb_update_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(SETS);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t          state;
    logic            rr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [IW-1:0]   idx;
    logic [63:0]     mem_pc  [DEPTH];
    logic [63:0]     mem_tgt [DEPTH];
    logic            mem_tk  [DEPTH];
    logic            upd_valid, upd_taken;
    logic [63:0]     upd_pc, upd_tgt;

    logic [CW-1:0]   free;
    logic            rdy0, rdy1, acc0, acc1, acc_fav, acc_oth;
    logic            first_v, second_v, first_sel1, popping;
    logic [63:0]     f_pc, f_tgt, s_pc, s_tgt;
    logic            f_tk, s_tk;
    logic            first_merge, second_merge, first_store, second_store;
    logic [PW-1:0]   s_slot;
`ifdef BTB_UPD_COALESCE_EN
    logic [PW-1:0]   tail, young_slot;
    logic [63:0]     young_pc;
    logic            young_ok;
`endif

    function automatic logic [63:0] flush_pc(input logic [IW-1:0] i);
        return {{(64-IW){1'b0}}, i} << IDX_LSB;
    endfunction

    always_comb begin
        free    = CW'(DEPTH) - count;
        rdy0    = rst_n && state == RUN && !bus.flush_i &&
                  (free >= CW'(2) || (free == CW'(1) && !rr));
        rdy1    = rst_n && state == RUN && !bus.flush_i &&
                  (free >= CW'(2) || (free == CW'(1) && rr));
        acc0    = bus.req0_valid_i && rdy0;
        acc1    = bus.req1_valid_i && rdy1;
        acc_fav = rr ? acc1 : acc0;
        acc_oth = rr ? acc0 : acc1;
        first_v  = acc_fav || acc_oth;
        second_v = acc_fav && acc_oth;
        // "first" is the older of this cycle's accepts; "second" is always the non-favoured side
        first_sel1 = acc_fav ? rr : !rr;
        f_pc  = first_sel1 ? bus.req1_pc_i     : bus.req0_pc_i;
        f_tgt = first_sel1 ? bus.req1_target_i : bus.req0_target_i;
        f_tk  = first_sel1 ? bus.req1_taken_i  : bus.req0_taken_i;
        s_pc  = rr ? bus.req0_pc_i     : bus.req1_pc_i;
        s_tgt = rr ? bus.req0_target_i : bus.req1_target_i;
        s_tk  = rr ? bus.req0_taken_i  : bus.req1_taken_i;
        popping = count != '0;
`ifdef BTB_UPD_COALESCE_EN
        // With count==1 the only stored entry is leaving this cycle, so it cannot absorb a merge
        tail        = wr_ptr - PW'(1);
        first_merge = first_v && count >= CW'(2) && f_pc == mem_pc[tail];
        young_ok    = 1'b0;
        young_pc    = mem_pc[tail];
        young_slot  = tail;
        if (first_v && !first_merge && popping) begin
            young_ok   = 1'b1;
            young_pc   = f_pc;
            young_slot = wr_ptr;
        end else if (!(first_v && !first_merge)) begin
            young_ok   = count >= CW'(2);
        end
        second_merge = second_v && young_ok && s_pc == young_pc;
`else
        first_merge  = 1'b0;
        second_merge = 1'b0;
`endif
        // With an empty FIFO the first accept bypasses storage straight into the output register
        first_store  = first_v && !first_merge && popping;
        second_store = second_v && !second_merge;
        s_slot       = first_store ? wr_ptr + PW'(1) : wr_ptr;
    end

    always_ff @(posedge clk) begin
        if (first_store) begin
            mem_pc[wr_ptr]  <= f_pc;
            mem_tgt[wr_ptr] <= f_tgt;
            mem_tk[wr_ptr]  <= f_tk;
        end
        if (second_store) begin
            mem_pc[s_slot]  <= s_pc;
            mem_tgt[s_slot] <= s_tgt;
            mem_tk[s_slot]  <= s_tk;
        end
`ifdef BTB_UPD_COALESCE_EN
        if (first_merge) begin
            mem_tgt[tail] <= f_tgt;
            mem_tk[tail]  <= f_tk;
        end
        if (second_merge) begin
            mem_tgt[young_slot] <= s_tgt;
            mem_tk[young_slot]  <= s_tk;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            rr        <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            idx       <= '0;
            upd_valid <= 1'b0;
            upd_pc    <= '0;
            upd_tgt   <= '0;
            upd_taken <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.flush_i) begin
                        state     <= FLUSH;
                        count     <= '0;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        idx       <= '0;
                        upd_valid <= 1'b1;
                        upd_pc    <= flush_pc('0);
                        upd_tgt   <= '0;
                        upd_taken <= 1'b0;
                    end else begin
                        if (acc_fav) rr <= !rr;
                        wr_ptr <= wr_ptr + PW'(first_store) + PW'(second_store);
                        count  <= count + CW'(first_store) + CW'(second_store) - CW'(popping);
                        if (popping) begin
                            upd_valid <= 1'b1;
                            upd_pc    <= mem_pc[rd_ptr];
                            upd_tgt   <= mem_tgt[rd_ptr];
                            upd_taken <= mem_tk[rd_ptr];
                            rd_ptr    <= rd_ptr + PW'(1);
                        end else if (first_v) begin
                            upd_valid <= 1'b1;
                            upd_pc    <= f_pc;
                            upd_tgt   <= f_tgt;
                            upd_taken <= f_tk;
                        end else begin
                            upd_valid <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (idx == IW'(SETS - 1)) begin
                        state     <= RUN;
                        idx       <= '0;
                        upd_valid <= 1'b0;
                    end else begin
                        idx    <= idx + IW'(1);
                        upd_pc <= flush_pc(idx + IW'(1));
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.req0_ready_o     = rdy0;
    assign bus.req1_ready_o     = rdy1;
    assign bus.flush_busy_o     = state == FLUSH;
    assign bus.fifo_count_o     = count;
    assign bus.btb_upd_valid_o  = upd_valid;
    assign bus.btb_upd_pc_o     = upd_pc;
    assign bus.btb_upd_target_o = upd_tgt;
    assign bus.btb_upd_taken_o  = upd_taken;
endmodule
